// File: rtl/count_frame_tx.sv
// Serialises one 15-byte 8N1 UART frame for each accepted frequency measurement.
// The frame carries the sync byte, the flags, three raw 32-bit counts and a checksum.
module count_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        ready,
  input  logic [31:0] sig_sys_cnt,
  input  logic [31:0] sig_cnt,
  input  logic [31:0] ref_sys_cnt,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned    BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d, byte_q, byte_d;
  logic [95:0]   snap_q, snap_d;
  logic [7:0]    flags_q, flags_d, csum_q, csum_d;
  logic [6:0]    seq_q, seq_d;
  logic          ovr_q, ovr_d;
  logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;

  logic [95:0]   in_vec;
  logic [7:0]    capt_sum;
  logic [7:0]    cur_byte;
  logic [2:0]    data_idx;

  assign in_vec = {sig_sys_cnt, sig_cnt, ref_sys_cnt};

  // Checksum is formed from the live inputs at capture so it is ready before byte 14.
  always_comb begin
    capt_sum = {ovr_q, seq_q};
    for (int unsigned i = 0; i < 12; i++) begin
      capt_sum = capt_sum + in_vec[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    snap_d  = snap_q;
    flags_d = flags_q;
    csum_d  = csum_q;
    seq_d   = seq_q;
    ovr_d   = ovr_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (ready) begin
          snap_d  = in_vec;
          flags_d = {ovr_q, seq_q};
          csum_d  = capt_sum;
          ovr_d   = 1'b0;
          seq_d   = seq_q + 7'd1;
          state_d = SEND;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (ready) ovr_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d  = '0;
            byte_d = byte_q + 4'd1;
            if (byte_q == 4'd14) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              byte_d  = '0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next-cycle position so they can be registered.
  always_comb begin
    cur_byte = csum_q;
    if (byte_d == 4'd0) cur_byte = SYNC_BYTE;
    if (byte_d == 4'd1) cur_byte = flags_q;
    for (int unsigned i = 0; i < 12; i++) begin
      if (byte_d == 4'(i + 2)) cur_byte = snap_q[8*(11-i) +: 8];
    end
    data_idx = 3'(bit_d - 4'd1);
    tx_d     = 1'b1;
    if (state_d == SEND) begin
      if (bit_d == 4'd0)      tx_d = 1'b0;
      else if (bit_d == 4'd9) tx_d = 1'b1;
      else                    tx_d = cur_byte[data_idx];
    end
    done_d = (state_d == SEND) && (byte_d == 4'd14) && (bit_d == 4'd9) &&
             (baud_d == BAUD_LAST);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      snap_q  <= '0;
      flags_q <= '0;
      csum_q  <= '0;
      seq_q   <= '0;
      ovr_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      snap_q  <= snap_d;
      flags_q <= flags_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_count_frame_tx.sv
// Bench for count_frame_tx: two instances (4 and 2 clocks per bit) checked cycle by
// cycle against a frame model built from the byte-layout and timing rules.
module tb_count_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n, ready, sel;
  logic [31:0] a, b, c;
  logic        rdy4, rdy2;
  logic        tx4, busy4, fd4, tx2, busy2, fd2;
  logic        tx_o, busy_o, fd_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] seq_m [2];
  logic       ov_m  [2];
  logic [7:0] exp_b [15];
  logic [7:0] rx_b  [15];

  always #5 clk = ~clk;

  assign rdy4   = ready && !sel;
  assign rdy2   = ready && sel;
  assign tx_o   = sel ? tx2 : tx4;
  assign busy_o = sel ? busy2 : busy4;
  assign fd_o   = sel ? fd2 : fd4;

  count_frame_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) u4 (
    .sys_clk(clk), .rst_n(rst_n), .ready(rdy4),
    .sig_sys_cnt(a), .sig_cnt(b), .ref_sys_cnt(c),
    .tx(tx4), .busy(busy4), .frame_done(fd4));

  count_frame_tx #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'hA5)) u2 (
    .sys_clk(clk), .rst_n(rst_n), .ready(rdy2),
    .sig_sys_cnt(a), .sig_cnt(b), .ref_sys_cnt(c),
    .tx(tx2), .busy(busy2), .frame_done(fd2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int cpb();
    return sel ? 2 : 4;
  endfunction

  task automatic build_expected(input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] vc);
    int s;
    logic [7:0] cs;
    s = sel ? 1 : 0;
    exp_b[0] = 8'hA5;
    exp_b[1] = {ov_m[s], seq_m[s]};
    for (int i = 0; i < 4; i++) begin
      exp_b[2+i]  = va[31-8*i -: 8];
      exp_b[6+i]  = vb[31-8*i -: 8];
      exp_b[10+i] = vc[31-8*i -: 8];
    end
    cs = 8'h00;
    for (int i = 1; i < 14; i++) cs = cs + exp_b[i];
    exp_b[14] = cs;
    ov_m[s]  = 1'b0;
    seq_m[s] = seq_m[s] + 7'd1;
  endtask

  // One frame: idle check, capture, then every cycle of the frame against the model.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc,
                      input int drop1, input int drop2, input bit clobber, input int abort_k);
    int n, p, s;
    p = cpb();
    n = 150 * p;
    s = sel ? 1 : 0;
    @(negedge clk);
    check("idle_tx", tx_o, 1);
    check("idle_busy", busy_o, 0);
    check("idle_done", fd_o, 0);
    a = va; b = vb; c = vc;
    ready = 1'b1;
    build_expected(va, vb, vc);
    for (int k = 1; k <= n; k++) begin
      int bp, by, bi;
      logic eb;
      @(negedge clk);
      bp = (k - 1) / p;
      by = bp / 10;
      bi = bp % 10;
      eb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : exp_b[by][bi-1];
      check("tx", tx_o, eb);
      check("busy", busy_o, 1);
      check("frame_done", fd_o, (k == n));
      if (((k - 1) % p) == (p / 2) && bi >= 1 && bi <= 8) rx_b[by][bi-1] = tx_o;
      if (k == abort_k) begin
        #1 rst_n = 1'b0;
        ready = 1'b0;
        #1;
        check("rst_tx", tx_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", fd_o, 0);
        seq_m[0] = '0; seq_m[1] = '0;
        ov_m[0] = 1'b0; ov_m[1] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("rst_hold_tx", tx_o, 1);
          check("rst_hold_done", fd_o, 0);
        end
        rst_n = 1'b1;
        return;
      end
      ready = (k == drop1) || (k == drop2);
      if (ready) ov_m[s] = 1'b1;
      if (clobber && k == 1) begin
        a = '1; b = '1; c = '1;
      end
    end
    if (ready) begin
      @(posedge clk);
      #1 ready = 1'b0;
    end
    for (int i = 0; i < 15; i++) check($sformatf("byte%0d", i), rx_b[i], exp_b[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    seq_m[0] = '0; seq_m[1] = '0;
    ov_m[0] = 1'b0; ov_m[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst_n = 1'b0; ready = 1'b0;
    a = '0; b = '0; c = '0;
    seq_m[0] = '0; seq_m[1] = '0;
    ov_m[0] = 1'b0; ov_m[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx4", tx4, 1);
    check("reset_busy4", busy4, 0);
    check("reset_done4", fd4, 0);
    check("reset_tx2", tx2, 1);
    check("reset_busy2", busy2, 0);
    check("reset_done2", fd2, 0);
    rst_n = 1'b1;

    // Reference frame with two strobes dropped mid-frame, then the overrun report.
    send(32'h11223344, 32'h55667788, 32'h99AABBCC, 100, 300, 1'b0, -1);
    check("t1_flags", rx_b[1], 8'h00);
    check("t1_csum", rx_b[14], 8'h2E);
    send($urandom, $urandom, $urandom, -1, -1, 1'b0, -1);
    check("ovr_flags", rx_b[1], 8'h81);
    send($urandom, $urandom, $urandom, -1, -1, 1'b0, -1);
    check("post_ovr_flags", rx_b[1], 8'h02);

    // Inputs change to all-ones right after capture.
    send($urandom, $urandom, $urandom, -1, -1, 1'b1, -1);

    // Strobe coincident with frame_done is dropped; the following cycle is accepted.
    send($urandom, $urandom, $urandom, 600, -1, 1'b0, -1);
    send($urandom, $urandom, $urandom, -1, -1, 1'b0, -1);
    check("bnd4_ovr", rx_b[1][7], 1);
    send($urandom, $urandom, $urandom, -1, -1, 1'b0, -1);
    check("bnd4_clear", rx_b[1][7], 0);

    // Reset at the start bit of byte 7.
    send(32'h11223344, 32'h55667788, 32'h99AABBCC, -1, -1, 1'b0, 70 * 4 + 1);
    send($urandom, $urandom, $urandom, -1, -1, 1'b0, -1);
    check("after_rst_flags", rx_b[1], 8'h00);

    sel = 1'b1;
    send($urandom, $urandom, $urandom, 300, -1, 1'b0, -1);
    send($urandom, $urandom, $urandom, -1, -1, 1'b0, -1);
    check("bnd2_ovr", rx_b[1][7], 1);

    // Sequence number wrap.
    do_reset();
    for (int f = 0; f < 128; f++) send($urandom, $urandom, $urandom, -1, -1, 1'b0, -1);
    send($urandom, $urandom, $urandom, -1, -1, 1'b0, -1);
    check("wrap_flags", rx_b[1], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
